// File: rtl/axis_window_mc_pkg.sv
// axis_window_pkg: shared FSM state type and fixed-point helpers for axis_window_mc
package axis_window_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic longint round_const(input int frac);
        return longint'(1) <<< (frac - 1);
    endfunction

    function automatic longint saturate(input longint v, input int w);
        longint hi;
        hi = (longint'(1) <<< (w - 1)) - 1;
        return v > hi ? hi : (v < -hi - 1) ? -hi - 1 : v;
    endfunction

endpackage

// File: rtl/axis_window_mc_if.sv
// axis_window_mc_if: AXI-Stream bundle (tdata/tlast/tvalid/tready) with master/slave views
interface axis_window_mc_if #(
    parameter int W = 16
) ();
    logic [W-1:0] tdata;
    logic         tlast;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, tlast, tvalid, input tready);
    modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_window_mc_coeff_ram.sv
// window_coeff_ram: simple dual-port read-first coefficient RAM (we/waddr/wdata write, re/raddr -> rdata one cycle later)
module window_coeff_ram #(
    parameter int DEPTH = 1024,
    parameter int W     = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/axis_window_mc.sv
// axis_window_mc: windows an N-channel interleaved AXI-Stream with RAM-held coefficients
//   aclk/reset: clock, sync active-high reset; start/abort/continuous/frame_len: frame control
//   coeff_we/coeff_waddr/coeff_wdata: coefficient load; s_axis/m_axis: stream in/out
//   busy: frame running; frame_err: sticky upstream tlast mismatch
module axis_window_mc
    import axis_window_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int DATA_W     = 16,
    parameter int COEFF_W    = 16,
    parameter int COEFF_FRAC = 15,
    parameter int WIN_DEPTH  = 1024,
    parameter int ADDR_W     = $clog2(WIN_DEPTH)
) (
    input  logic               aclk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               continuous,
    input  logic [ADDR_W:0]    frame_len,
    input  logic               coeff_we,
    input  logic [ADDR_W-1:0]  coeff_waddr,
    input  logic [COEFF_W-1:0] coeff_wdata,
    axis_window_mc_if.slave    s_axis,
    axis_window_mc_if.master   m_axis,
    output logic               busy,
    output logic               frame_err
);
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;

    state_t                       state_q, state_d;
    logic [ADDR_W:0]              len_q, len_d;
    logic                         cont_q, cont_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [ADDR_W-1:0]            idx_q, idx_d;
    logic                         err_q, err_d;
    logic                         s1_valid_q, s1_valid_d;
    logic                         s1_last_q, s1_last_d;
    logic signed [DATA_W-1:0]     s1_data_q, s1_data_d;
    logic                         m_valid_q, m_valid_d;
    logic                         m_last_q, m_last_d;
    logic [2*DATA_W-1:0]          m_data_q, m_data_d;
    logic [COEFF_W-1:0]           coeff;
    logic                         run, en, acc, fin;
    logic signed [DATA_W+COEFF_W-1:0] prod;
    longint                       rounded, sat_v;

    window_coeff_ram #(.DEPTH(WIN_DEPTH), .W(COEFF_W), .AW(ADDR_W)) u_ram (
        .clk   (aclk),
        .we    (coeff_we),
        .waddr (coeff_waddr),
        .wdata (coeff_wdata),
        .re    (en),
        .raddr (idx_q),
        .rdata (coeff)
    );

    always_comb begin
        run        = state_q == RUN;
        en         = !m_valid_q || m_axis.tready;
        acc        = run && en && s_axis.tvalid;
        fin        = {1'b0, idx_q} == len_q - 1'b1 && ch_q == CH_W'(CHANNELS - 1);
        state_d    = state_q;
        len_d      = len_q;
        cont_d     = cont_q;
        ch_d       = ch_q;
        idx_d      = idx_q;
        err_d      = err_q;
        if (!run) begin
            if (start && !abort) begin
                state_d = RUN;
                len_d   = (frame_len == '0 || frame_len > (ADDR_W+1)'(WIN_DEPTH))
                          ? (ADDR_W+1)'(WIN_DEPTH) : frame_len;
                cont_d  = continuous;
                err_d   = 1'b0;
            end
        end else if (abort) begin
            state_d = IDLE;
            ch_d    = '0;
            idx_d   = '0;
        end else if (acc) begin
            err_d = err_q | (s_axis.tlast != fin);
            ch_d  = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
            idx_d = fin ? '0 : (ch_q == CH_W'(CHANNELS - 1)) ? idx_q + 1'b1 : idx_q;
            state_d = (fin && !cont_q) ? IDLE : RUN;
        end
        // A beat accepted in the abort cycle drains without tlast.
        s1_valid_d = en ? acc : s1_valid_q;
        s1_last_d  = en ? acc && fin && !abort : s1_last_q;
        s1_data_d  = en ? s_axis.tdata : s1_data_q;
        prod       = s1_data_q * $signed(coeff);
        rounded    = (longint'(prod) + round_const(COEFF_FRAC)) >>> COEFF_FRAC;
        sat_v      = saturate(rounded, DATA_W);
        m_valid_d  = en ? s1_valid_q : m_valid_q;
        m_last_d   = en ? s1_last_q : m_last_q;
        m_data_d   = en ? (s1_valid_q ? {{DATA_W{1'b0}}, sat_v[DATA_W-1:0]} : '0) : m_data_q;
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cont_q     <= 1'b0;
            ch_q       <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cont_q     <= cont_d;
            ch_q       <= ch_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_data_q  <= s1_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_data_q   <= m_data_d;
        end
    end

    assign s_axis.tready = run && en;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tdata  = m_data_q;
    assign busy          = run;
    assign frame_err     = err_q;
endmodule

// File: tb/tb_axis_window_mc.sv
// tb_axis_window_mc: randomized self-checking bench for axis_window_mc against a frame-level model
module tb_axis_window_mc;
    localparam int CH = 2;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    logic        clk, reset, start, abort, continuous;
    logic [10:0] frame_len;
    logic        coeff_we;
    logic [9:0]  coeff_waddr;
    logic [15:0] coeff_wdata;
    logic        busy, frame_err;
    logic        rdy_rand, gap_rand;

    logic [15:0] coef [1024];
    logic [15:0] pat[$];
    logic [15:0] outs[$];
    exp_t        expq[$];
    int          n_chk, n_pass, out_cnt, last_cnt;
    logic        stall_q;
    logic [31:0] hold_data;
    logic        hold_last;

    axis_window_mc_if #(.W(16)) s_if ();
    axis_window_mc_if #(.W(32)) m_if ();

    axis_window_mc dut (
        .aclk        (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .continuous  (continuous),
        .frame_len   (frame_len),
        .coeff_we    (coeff_we),
        .coeff_waddr (coeff_waddr),
        .coeff_wdata (coeff_wdata),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Round-half-up of d*c / 2^15, clamped to the 16-bit signed range.
    function automatic logic [15:0] ref_win(input logic [15:0] d, input logic [15:0] c);
        longint p, r;
        p = longint'($signed(d)) * longint'($signed(c));
        r = (p + 16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic wr(input int a, input logic [15:0] d);
        coeff_we = 1'b1;
        coeff_waddr = 10'(a);
        coeff_wdata = d;
        coef[a] = d;
        @(posedge clk); #1;
        coeff_we = 1'b0;
    endtask

    task automatic do_start(input logic [10:0] l, input logic c);
        start = 1'b1;
        frame_len = l;
        continuous = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic clear_cnt();
        out_cnt = 0;
        last_cnt = 0;
        outs.delete();
    endtask

    task automatic send(input int len_eff, input int nbeats, input int tl_beat);
        int total;
        total = len_eff * CH;
        for (int n = 0; n < nbeats; n++) begin
            logic [15:0] d;
            int b;
            if (gap_rand && $urandom_range(0, 3) == 0) begin
                s_if.tvalid = 1'b0;
                @(posedge clk); #1;
            end
            d = (n < pat.size()) ? pat[n] : 16'($urandom);
            s_if.tvalid = 1'b1;
            s_if.tdata = d;
            s_if.tlast = (tl_beat < 0) ? (n == total - 1) : (n == tl_beat);
            b = 0;
            forever begin
                @(negedge clk);
                if (s_if.tready) break;
                @(posedge clk); #1;
                b++;
                if (b > 200) break;
            end
            if (b > 200) begin
                chk("accept_timeout", 0, 1);
                s_if.tvalid = 1'b0;
                return;
            end
            expq.push_back('{ref_win(d, coef[n / CH]), n == total - 1});
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (expq.size() != 0 && b < 500) begin
            @(posedge clk); #1;
            b++;
        end
        chk("drain_left", expq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_tready"}, 32'(s_if.tready), 0);
        chk({tag, "_tvalid"}, 32'(m_if.tvalid), 0);
        chk({tag, "_tlast"}, 32'(m_if.tlast), 0);
        chk({tag, "_tdata"}, m_if.tdata, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(frame_err), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            m_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        stall_q = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    chk("hold_data", m_if.tdata, hold_data);
                    chk("hold_last", 32'(m_if.tlast), 32'(hold_last));
                end
                if (m_if.tvalid && m_if.tready) begin
                    if (expq.size() == 0) begin
                        chk("extra_beat", 1, 0);
                    end else begin
                        exp_t e;
                        e = expq.pop_front();
                        chk("out_data", m_if.tdata, {16'h0, e.d});
                        chk("out_last", 32'(m_if.tlast), 32'(e.l));
                        out_cnt++;
                        if (m_if.tlast) last_cnt++;
                        outs.push_back(m_if.tdata[15:0]);
                    end
                end
                stall_q = m_if.tvalid && !m_if.tready;
                hold_data = m_if.tdata;
                hold_last = m_if.tlast;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; frame_len = '0;
        coeff_we = 1'b0; coeff_waddr = '0; coeff_wdata = '0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
        m_if.tready = 1'b1; rdy_rand = 1'b0; gap_rand = 1'b0;
        clear_cnt();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        reset = 1'b0;

        for (int a = 0; a < 1024; a++) wr(a, 16'h4000);
        for (int i = 0; i < 8; i++) pat.push_back(16'h2000);
        clear_cnt();
        do_start(11'd4, 1'b0);
        chk("t1_busy_run", 32'(busy), 1);
        send(4, 8, -1);
        chk("t1_busy_done", 32'(busy), 0);
        chk("t1_tready_done", 32'(s_if.tready), 0);
        drain();
        chk("t1_count", out_cnt, 8);
        chk("t1_lasts", last_cnt, 1);
        foreach (outs[i]) chk("t1_value", 32'(outs[i]), 32'h1000);
        chk("t1_err", 32'(frame_err), 0);

        wr(0, 16'h7FFF);
        wr(1, 16'h8000);
        pat = '{16'h8000, 16'h7FFF, 16'h8000, 16'h1234};
        clear_cnt();
        do_start(11'd2, 1'b0);
        send(2, 4, -1);
        drain();
        pat.delete();
        chk("t2_count", out_cnt, 4);
        if (outs.size() >= 3) begin
            chk("t2_neg", 32'(outs[0]), 32'h8001);
            chk("t2_pos", 32'(outs[1]), 32'h7FFE);
            chk("t2_sat", 32'(outs[2]), 32'h7FFF);
        end

        for (int a = 0; a < 16; a++) wr(a, 16'($urandom));
        rdy_rand = 1'b1;
        gap_rand = 1'b1;
        clear_cnt();
        do_start(11'd16, 1'b1);
        for (int f = 0; f < 3; f++) send(16, 32, -1);
        chk("t3_busy_cont", 32'(busy), 1);
        pulse_abort();
        drain();
        rdy_rand = 1'b0;
        gap_rand = 1'b0;
        chk("t3_count", out_cnt, 96);
        chk("t3_lasts", last_cnt, 3);
        chk("t3_busy_end", 32'(busy), 0);

        clear_cnt();
        do_start(11'd4, 1'b0);
        send(4, 8, 4);
        drain();
        chk("t4_err", 32'(frame_err), 1);
        chk("t4_count", out_cnt, 8);
        chk("t4_lasts", last_cnt, 1);

        for (int a = 0; a < 4; a++) wr(a, 16'($urandom));
        clear_cnt();
        do_start(11'd8, 1'b0);
        chk("t5_err_clear", 32'(frame_err), 0);
        send(8, 3, -1);
        pulse_abort();
        chk("t5_busy_abort", 32'(busy), 0);
        drain();
        chk("t5_drain_count", out_cnt, 3);
        chk("t5_drain_lasts", last_cnt, 0);
        clear_cnt();
        do_start(11'd2, 1'b0);
        send(2, 4, -1);
        drain();
        chk("t5_restart_count", out_cnt, 4);
        chk("t5_restart_lasts", last_cnt, 1);

        clear_cnt();
        do_start(11'd0, 1'b0);
        send(1024, 2048, -1);
        chk("t6_len0_busy", 32'(busy), 0);
        drain();
        chk("t6_len0_count", out_cnt, 2048);
        chk("t6_len0_lasts", last_cnt, 1);
        clear_cnt();
        do_start(11'd1029, 1'b0);
        send(1024, 2048, -1);
        chk("t6_big_busy", 32'(busy), 0);
        drain();
        chk("t6_big_count", out_cnt, 2048);
        chk("t6_big_lasts", last_cnt, 1);

        do_start(11'd1029, 1'b0);
        send(1024, 100, -1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("midrst");
        reset = 1'b0;
        expq.delete();
        clear_cnt();
        do_start(11'd4, 1'b0);
        send(4, 8, -1);
        drain();
        chk("t6_post_rst_count", out_cnt, 8);
        chk("t6_post_rst_lasts", last_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
